mtimer_multi: RTL and testbench
===============================

Name: mtimer_multi

Overview:
- Parametrised successor to the single-compare machine timer: one 64-bit free-running counter with programmable prescaler and NUM_CMP independent 64-bit compare channels.
- Each channel has sticky pending and enable bits.
- Counter-high snapshot on low-word read gives tear-free 64-bit reads.
- Wishbone slave on the CPU data bus; drives per-channel and combined interrupt lines to the interrupt controller/core.

Parameters:
BASE_ADDRESS, 0, byte address of word offset 0
NUM_CMP, 4, number of compare channels (1..16)
PRESCALE_WIDTH, 16, width of prescaler reload register (1..32)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
stb_i  in  1  wishbone strobe
cyc_i  in  1  wishbone cycle
adr_i  in  32  wishbone byte address
sel_i  in  4  byte selects
dat_i  in  32  write data
dat_o  out  32  read data; driven only while ack_o=1, else high-impedance
we_i  in  1  write enable
ack_o  out  1  acknowledge
err_o  out  1  error (always 0)
rty_o  out  1  retry (always 0)
interrupt_enable  in  1  global gate for interrupt
irq_vec  out  NUM_CMP  per-channel pending & enable (combinational from registers)
interrupt  out  1  registered OR of irq_vec, gated by interrupt_enable

Behaviour:
- Reset (rst_i=1, asynchronous): all registers, shadow, prescaler, ack_o, interrupt = 0. err_o and rty_o are always 0.
- Register map (word offset = (adr_i-BASE_ADDRESS)>>2); region size 8+2*NUM_CMP words:
  - 0 MTIME_LO
  - 1 MTIME_HI
  - 2 CTRL: bit0 RUN; bit1 CLR, write-1 self-clearing
  - 3 PRESCALE
  - 4 PENDING: read, write-1-to-clear
  - 5 IRQ_EN
  - 6, 7 reserved: read 0, writes ignored
  - 8+2k CMP_LO[k]; 9+2k CMP_HI[k]
- Addressed: adr_i >= BASE_ADDRESS and offset < size. Unaddressed accesses are ignored; no ack.
- Bus timing:
  - When stb_i & cyc_i & addressed & !ack_o: ack_o=1 on the next edge for exactly one cycle.
  - Back-to-back requests get ack every other cycle.
  - Read data is registered in the same edge.
- Byte writes: sel_i honoured per byte on all writable registers. Bits above PRESCALE_WIDTH and above NUM_CMP in PENDING/IRQ_EN read 0.
- Prescaler:
  - While RUN=1, prescaler counts 0..PRESCALE.
  - A tick occurs on the cycle it equals PRESCALE; it then wraps to 0.
  - PRESCALE=0 means a tick every cycle.
  - RUN=0 freezes both the prescaler and mtime.
- Counter: on a tick, mtime <= mtime+1, 64-bit with carry into HI. 0xFFFF_FFFF_FFFF_FFFF wraps to 0.
- Counter write precedence (highest first):
  - CLR write: mtime=0, prescaler=0.
  - MTIME_LO/HI write: written bytes take dat_i; unwritten bytes hold; no increment that cycle; prescaler reset to 0.
  - Otherwise a tick increments.
- Atomic read: reading MTIME_LO returns current LO and latches current HI into shadow. Reading MTIME_HI returns shadow. Shadow is untouched by writes.
- Compare:
  - match[k] = (mtime >= cmp[k]), unsigned, 64-bit, evaluated on registered values each cycle.
  - pending[k] is set every cycle match[k]=1, regardless of IRQ_EN.
  - Write-1-to-PENDING clears bit k only if match[k]=0 that cycle; set wins.
  - Writing cmp[k] above mtime, then W1C, retires the interrupt.
- interrupt <= interrupt_enable & |(pending & IRQ_EN), one cycle after pending/enable change.
- Reset mid-transaction: ack_o drops immediately. No partial write survives.

Test Plan:
- Reset, RUN=1, PRESCALE=0, 10 idle cycles -> MTIME_LO read returns 10±bus latency (exact value checked against cycle count); MTIME_HI = 0.
- PRESCALE=3, RUN=1 -> mtime increments once per 4 cycles. RUN=0 -> value frozen over 20 cycles.
- Write MTIME_LO=0xFFFF_FFFE, HI=0, PRESCALE=0 -> after 2 ticks LO=0, HI=1. Read LO while HI changes, then read HI -> pair equals a single coherent snapshot.
- NUM_CMP=4: CMP[2]={0,100}, IRQ_EN=0x4, interrupt_enable=1 -> irq_vec=0b0100 when mtime reaches 100; interrupt one cycle later. W1C PENDING while still matching -> bit stays set. Write CMP[2]=1000, then W1C -> interrupt falls.
- Byte-select write sel_i=0b0010, dat_i=0x0000_AB00 to CMP_LO[0]=0x1122_3344 -> reads 0x1122_AB44. Access to offset 6 and to BASE_ADDRESS+4*(8+2*NUM_CMP) -> 0 / no ack respectively.
- Assert rst_i asynchronously mid-count with pending set and ack_o high -> all outputs 0 before the next clock edge.

Source files
------------

// File: rtl/mtimer_multi.sv
// mtimer_multi: 64-bit machine timer with programmable prescaler and
// NUM_CMP independent 64-bit compare channels, on a Wishbone slave port.
//
// Ports:
//   clk_i, rst_i           clock, asynchronous active-high reset
//   stb_i, cyc_i, we_i     Wishbone strobe / cycle / write enable
//   adr_i, sel_i, dat_i    byte address, byte selects, write data
//   dat_o                  read data, driven only while ack_o=1 (else Z)
//   ack_o, err_o, rty_o    acknowledge (one cycle), error/retry tied 0
//   interrupt_enable       global gate for the combined interrupt
//   irq_vec                per-channel pending & enable
//   interrupt              registered, gated OR of irq_vec
//
// Word map (offset from BASE_ADDRESS, in 32-bit words):
//   0 MTIME_LO, 1 MTIME_HI (shadow), 2 CTRL {CLR,RUN}, 3 PRESCALE,
//   4 PENDING (W1C), 5 IRQ_EN, 6..7 reserved, 8+2k CMP_LO[k], 9+2k CMP_HI[k]
module mtimer_multi #(
  parameter logic [31:0] BASE_ADDRESS   = 32'h0,
  parameter int unsigned NUM_CMP        = 4,
  parameter int unsigned PRESCALE_WIDTH = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               stb_i,
  input  logic               cyc_i,
  input  logic [31:0]        adr_i,
  input  logic [3:0]         sel_i,
  input  logic [31:0]        dat_i,
  output logic [31:0]        dat_o,
  input  logic               we_i,
  output logic               ack_o,
  output logic               err_o,
  output logic               rty_o,
  input  logic               interrupt_enable,
  output logic [NUM_CMP-1:0] irq_vec,
  output logic               interrupt
);

  localparam int unsigned REGION_WORDS = 8 + 2 * NUM_CMP;
  localparam int unsigned PW           = PRESCALE_WIDTH;

  localparam logic [31:0] OFF_MTIME_LO = 32'd0;
  localparam logic [31:0] OFF_MTIME_HI = 32'd1;
  localparam logic [31:0] OFF_CTRL     = 32'd2;
  localparam logic [31:0] OFF_PRESCALE = 32'd3;
  localparam logic [31:0] OFF_PENDING  = 32'd4;
  localparam logic [31:0] OFF_IRQ_EN   = 32'd5;

  // Replace selected bytes of old with the matching bytes of new.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [31:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  logic [32:0]        rel_addr;
  logic [31:0]        word_off;
  logic               addressed;
  logic               req;
  logic               wr;
  logic               rd;
  logic [31:0]        wmask;

  logic [63:0]        mtime_q;
  logic [PW-1:0]      presc_cnt_q;
  logic [PW-1:0]      presc_q;
  logic               run_q;
  logic [NUM_CMP-1:0] pending_q;
  logic [NUM_CMP-1:0] irq_en_q;
  logic [63:0]        cmp_q [NUM_CMP];
  logic [31:0]        shadow_q;
  logic [31:0]        rdata_q;
  logic               ack_q;
  logic               int_q;

  logic               tick;
  logic [NUM_CMP-1:0] match;
  logic [NUM_CMP-1:0] pend_clr;
  logic [31:0]        rdata_c;
  logic               wr_mtime_lo;
  logic               wr_mtime_hi;
  logic               wr_ctrl;
  logic               wr_clr;
  logic               wr_presc;
  logic               wr_pending;
  logic               wr_irq_en;

  // Address decode: 33-bit subtraction flags addresses below the base.
  assign rel_addr  = {1'b0, adr_i} - {1'b0, BASE_ADDRESS};
  assign word_off  = 32'(rel_addr >> 2);
  assign addressed = !rel_addr[32] && (word_off < 32'(REGION_WORDS));
  assign req       = stb_i && cyc_i && addressed && !ack_q;
  assign wr        = req && we_i;
  assign rd        = req && !we_i;
  assign wmask     = {{8{sel_i[3]}}, {8{sel_i[2]}}, {8{sel_i[1]}}, {8{sel_i[0]}}};

  assign wr_mtime_lo = wr && (word_off == OFF_MTIME_LO);
  assign wr_mtime_hi = wr && (word_off == OFF_MTIME_HI);
  assign wr_ctrl     = wr && (word_off == OFF_CTRL);
  assign wr_clr      = wr_ctrl && sel_i[0] && dat_i[1];
  assign wr_presc    = wr && (word_off == OFF_PRESCALE);
  assign wr_pending  = wr && (word_off == OFF_PENDING);
  assign wr_irq_en   = wr && (word_off == OFF_IRQ_EN);

  assign tick     = run_q && (presc_cnt_q == presc_q);
  assign pend_clr = wr_pending ? NUM_CMP'(dat_i & wmask) : '0;

  // Unsigned 64-bit compare of each channel against the registered counter.
  always_comb begin
    match = '0;
    for (int k = 0; k < NUM_CMP; k++) begin
      match[k] = (mtime_q >= cmp_q[k]);
    end
  end

  // Read multiplexer.
  always_comb begin
    rdata_c = '0;
    case (word_off)
      OFF_MTIME_LO: rdata_c = mtime_q[31:0];
      OFF_MTIME_HI: rdata_c = shadow_q;
      OFF_CTRL:     rdata_c = {31'b0, run_q};
      OFF_PRESCALE: rdata_c = 32'(presc_q);
      OFF_PENDING:  rdata_c = 32'(pending_q);
      OFF_IRQ_EN:   rdata_c = 32'(irq_en_q);
      default: begin
        for (int k = 0; k < NUM_CMP; k++) begin
          if (word_off == 32'(8 + 2 * k)) rdata_c = cmp_q[k][31:0];
          if (word_off == 32'(9 + 2 * k)) rdata_c = cmp_q[k][63:32];
        end
      end
    endcase
  end

  // Bus handshake, read data capture and the MTIME_HI shadow.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_q    <= 1'b0;
      rdata_q  <= '0;
      shadow_q <= '0;
    end else begin
      ack_q <= req;
      if (req) rdata_q <= we_i ? 32'h0 : rdata_c;
      if (rd && (word_off == OFF_MTIME_LO)) shadow_q <= mtime_q[63:32];
    end
  end

  // Counter and prescaler; CLR beats a direct write, which beats a tick.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mtime_q     <= '0;
      presc_cnt_q <= '0;
    end else if (wr_clr) begin
      mtime_q     <= '0;
      presc_cnt_q <= '0;
    end else if (wr_mtime_lo || wr_mtime_hi) begin
      if (wr_mtime_lo) mtime_q[31:0]  <= merge_bytes(mtime_q[31:0], dat_i, wmask);
      if (wr_mtime_hi) mtime_q[63:32] <= merge_bytes(mtime_q[63:32], dat_i, wmask);
      presc_cnt_q <= '0;
    end else if (run_q) begin
      if (tick) begin
        mtime_q     <= mtime_q + 64'd1;
        presc_cnt_q <= '0;
      end else begin
        presc_cnt_q <= presc_cnt_q + PW'(1);
      end
    end
  end

  // Control, prescale reload, enables, sticky pending and interrupt.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      run_q     <= 1'b0;
      presc_q   <= '0;
      irq_en_q  <= '0;
      pending_q <= '0;
      int_q     <= 1'b0;
    end else begin
      if (wr_ctrl && sel_i[0]) run_q <= dat_i[0];
      if (wr_presc)  presc_q  <= PW'(merge_bytes(32'(presc_q), dat_i, wmask));
      if (wr_irq_en) irq_en_q <= NUM_CMP'(merge_bytes(32'(irq_en_q), dat_i, wmask));
      // A live match re-asserts pending even in the cycle it is cleared.
      pending_q <= (pending_q & ~pend_clr) | match;
      int_q     <= interrupt_enable && |(pending_q & irq_en_q);
    end
  end

  // Compare value registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < NUM_CMP; k++) cmp_q[k] <= '0;
    end else if (wr) begin
      for (int k = 0; k < NUM_CMP; k++) begin
        if (word_off == 32'(8 + 2 * k))
          cmp_q[k][31:0] <= merge_bytes(cmp_q[k][31:0], dat_i, wmask);
        if (word_off == 32'(9 + 2 * k))
          cmp_q[k][63:32] <= merge_bytes(cmp_q[k][63:32], dat_i, wmask);
      end
    end
  end

  assign ack_o     = ack_q;
  assign err_o     = 1'b0;
  assign rty_o     = 1'b0;
  assign dat_o     = ack_q ? rdata_q : 'z;
  assign irq_vec   = pending_q & irq_en_q;
  assign interrupt = int_q;

endmodule

// File: tb/tb_mtimer_multi.sv
// Self-checking bench for mtimer_multi (NUM_CMP=4, PRESCALE_WIDTH=16, base 0).
module tb_mtimer_multi;

  localparam int unsigned NUM_CMP = 4;
  localparam int unsigned NVEC    = 23;

  localparam logic [31:0] A_LO   = 32'd0;
  localparam logic [31:0] A_HI   = 32'd4;
  localparam logic [31:0] A_CTRL = 32'd8;
  localparam logic [31:0] A_PRE  = 32'd12;
  localparam logic [31:0] A_PEND = 32'd16;
  localparam logic [31:0] A_IEN  = 32'd20;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               stb_i;
  logic               cyc_i;
  logic [31:0]        adr_i;
  logic [3:0]         sel_i;
  logic [31:0]        dat_i;
  logic [31:0]        dat_o;
  logic               we_i;
  logic               ack_o;
  logic               err_o;
  logic               rty_o;
  logic               interrupt_enable;
  logic [NUM_CMP-1:0] irq_vec;
  logic               interrupt;

  int checks    = 0;
  int errors    = 0;
  int cycle_cnt = 0;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        exp_ack;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [NVEC];

  mtimer_multi #(
    .BASE_ADDRESS  (32'h0),
    .NUM_CMP       (NUM_CMP),
    .PRESCALE_WIDTH(16)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .stb_i           (stb_i),
    .cyc_i           (cyc_i),
    .adr_i           (adr_i),
    .sel_i           (sel_i),
    .dat_i           (dat_i),
    .dat_o           (dat_o),
    .we_i            (we_i),
    .ack_o           (ack_o),
    .err_o           (err_o),
    .rty_o           (rty_o),
    .interrupt_enable(interrupt_enable),
    .irq_vec         (irq_vec),
    .interrupt       (interrupt)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cycle_cnt <= cycle_cnt + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One Wishbone access; returns sampled data/ack and the capture-edge count.
  task automatic bus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                     input logic [3:0] sel, output logic [31:0] rdat,
                     output logic acked, output int cap);
    @(negedge clk_i);
    stb_i = 1'b1; cyc_i = 1'b1; we_i = we; adr_i = adr; dat_i = dat; sel_i = sel;
    @(posedge clk_i);
    #1;
    acked = ack_o;
    rdat  = dat_o;
    cap   = cycle_cnt;
    @(negedge clk_i);
    stb_i = 1'b0; cyc_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] dat, output int cap);
    logic [31:0] d;
    logic        a;
    bus(1'b1, adr, dat, 4'hF, d, a, cap);
  endtask

  task automatic rd(input logic [31:0] adr, output logic [31:0] d, output int cap);
    logic a;
    bus(1'b0, adr, 32'h0, 4'hF, d, a, cap);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rv;
    logic [31:0] rh;
    logic        ackd;
    logic [63:0] exp64;
    int          c0, c1, c2, cs;
    int          fr;
    logic        found;

    vecs[0]  = '{1'b1, 32'd32, 32'h1122_3344, 4'hF, 1'b1, 32'h0};
    vecs[1]  = '{1'b1, 32'd32, 32'h0000_AB00, 4'h2, 1'b1, 32'h0};
    vecs[2]  = '{1'b0, 32'd32, 32'h0,         4'hF, 1'b1, 32'h1122_AB44};
    vecs[3]  = '{1'b1, 32'd36, 32'hAABB_CCDD, 4'h9, 1'b1, 32'h0};
    vecs[4]  = '{1'b0, 32'd36, 32'h0,         4'hF, 1'b1, 32'hAA00_00DD};
    vecs[5]  = '{1'b1, 32'd24, 32'hDEAD_BEEF, 4'hF, 1'b1, 32'h0};
    vecs[6]  = '{1'b0, 32'd24, 32'h0,         4'hF, 1'b1, 32'h0};
    vecs[7]  = '{1'b0, 32'd28, 32'h0,         4'hF, 1'b1, 32'h0};
    vecs[8]  = '{1'b0, 32'd64, 32'h0,         4'hF, 1'b0, 32'h0};
    vecs[9]  = '{1'b1, 32'd64, 32'h1234_5678, 4'hF, 1'b0, 32'h0};
    vecs[10] = '{1'b1, A_IEN,  32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0};
    vecs[11] = '{1'b0, A_IEN,  32'h0,         4'hF, 1'b1, 32'h0000_000F};
    vecs[12] = '{1'b1, A_PRE,  32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0};
    vecs[13] = '{1'b0, A_PRE,  32'h0,         4'hF, 1'b1, 32'h0000_FFFF};
    vecs[14] = '{1'b1, A_PRE,  32'h0,         4'h1, 1'b1, 32'h0};
    vecs[15] = '{1'b0, A_PRE,  32'h0,         4'hF, 1'b1, 32'h0000_FF00};
    vecs[16] = '{1'b1, A_PRE,  32'h0,         4'hF, 1'b1, 32'h0};
    vecs[17] = '{1'b1, A_IEN,  32'h0,         4'hF, 1'b1, 32'h0};
    vecs[18] = '{1'b0, A_CTRL, 32'h0,         4'hF, 1'b1, 32'h0};
    vecs[19] = '{1'b0, A_PEND, 32'h0,         4'hF, 1'b1, 32'h0000_000F};
    vecs[20] = '{1'b1, A_PEND, 32'h0000_000F, 4'hF, 1'b1, 32'h0};
    vecs[21] = '{1'b0, A_PEND, 32'h0,         4'hF, 1'b1, 32'h0000_000E};
    vecs[22] = '{1'b0, 32'hFFFF_FFFC, 32'h0,  4'hF, 1'b0, 32'h0};

    rst_i = 1'b1; stb_i = 1'b0; cyc_i = 1'b0; we_i = 1'b0;
    adr_i = '0; sel_i = '0; dat_i = '0; interrupt_enable = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk_i);
    check("rst_ack", ack_o, 1'b0);
    check("rst_int", interrupt, 1'b0);
    check("rst_irqvec", irq_vec, '0);
    check("rst_err_rty", {err_o, rty_o}, 2'b00);
    rst_i = 1'b0;

    // Register access table.
    for (int i = 0; i < NVEC; i++) begin
      bus(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, rv, ackd, c0);
      check($sformatf("vec%0d_ack", i), ackd, vecs[i].exp_ack);
      if (!vecs[i].we && vecs[i].exp_ack)
        check($sformatf("vec%0d_data", i), rv, vecs[i].exp_rd);
    end

    // Free-running count with PRESCALE=0.
    wr(A_CTRL, 32'h1, c0);
    repeat (10) @(negedge clk_i);
    rd(A_LO, rv, c1);
    check("count_lo", rv, 32'(c1 - c0 - 1));
    rd(A_HI, rv, c2);
    check("count_hi", rv, 32'h0);

    // PRESCALE=3: one tick every 4 cycles, then freeze with RUN=0.
    wr(A_PRE, 32'd3, c2);
    wr(A_LO, 32'h0, c0);
    rd(A_LO, rv, c1);
    check("presc_a", rv, 32'((c1 - c0 - 1) / 4));
    repeat (7) @(negedge clk_i);
    rd(A_LO, rv, c1);
    check("presc_b", rv, 32'((c1 - c0 - 1) / 4));
    wr(A_CTRL, 32'h0, cs);
    fr = (cs - c0) / 4;
    rd(A_LO, rv, c1);
    check("freeze_a", rv, 32'(fr));
    repeat (20) @(negedge clk_i);
    rd(A_LO, rv, c1);
    check("freeze_b", rv, 32'(fr));

    // 32-bit carry and tear-free LO/HI pairs.
    wr(A_PRE, 32'h0, c2);
    wr(A_LO, 32'hFFFF_FFFE, c2);
    wr(A_HI, 32'h0, c2);
    wr(A_CTRL, 32'h1, c0);
    rd(A_LO, rv, c1);
    rd(A_HI, rh, c2);
    exp64 = 64'hFFFF_FFFE + 64'(c1 - c0 - 1);
    check("snap1", {rh, rv}, exp64);
    repeat (3) @(negedge clk_i);
    rd(A_LO, rv, c1);
    rd(A_HI, rh, c2);
    exp64 = 64'hFFFF_FFFE + 64'(c1 - c0 - 1);
    check("snap2", {rh, rv}, exp64);
    check("snap2_hi", rh, 32'h1);

    // Compare channel 2 at mtime=100.
    wr(A_CTRL, 32'h2, c2);
    wr(32'd36, 32'hFFFF_FFFF, c2);
    wr(32'd44, 32'hFFFF_FFFF, c2);
    wr(32'd60, 32'hFFFF_FFFF, c2);
    wr(32'd52, 32'h0, c2);
    wr(32'd48, 32'd100, c2);
    wr(A_IEN, 32'h4, c2);
    wr(A_PEND, 32'hF, c2);
    rd(A_PEND, rv, c2);
    check("pend_clear", rv, 32'h0);
    interrupt_enable = 1'b1;
    @(negedge clk_i);
    check("irq_idle", {irq_vec, interrupt}, 5'b0);
    wr(A_CTRL, 32'h1, cs);
    found = 1'b0;
    c1 = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk_i);
      #1;
      if (irq_vec != '0) begin
        found = 1'b1;
        c1 = cycle_cnt;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL irq_timeout: irq_vec stayed 0 for 200 cycles");
    end else begin
      check("irq_cycle", c1 - cs, 101);
      check("irq_vec", irq_vec, 4'b0100);
      check("int_lag", interrupt, 1'b0);
      @(posedge clk_i);
      #1;
      check("int_rise", interrupt, 1'b1);
    end
    wr(A_PEND, 32'h4, c2);
    rd(A_PEND, rv, c2);
    check("pend_sticky", rv, 32'h4);
    wr(32'd48, 32'd1000, c2);
    wr(A_PEND, 32'h4, c2);
    check("irqvec_clr", irq_vec, 4'b0);
    check("int_hold", interrupt, 1'b1);
    @(posedge clk_i);
    #1;
    check("int_fall", interrupt, 1'b0);

    // Global gate, then asynchronous reset during an acked read.
    wr(32'd48, 32'd0, c2);
    repeat (3) @(negedge clk_i);
    check("int_again", interrupt, 1'b1);
    interrupt_enable = 1'b0;
    @(posedge clk_i);
    #1;
    check("int_gated", interrupt, 1'b0);
    interrupt_enable = 1'b1;
    @(negedge clk_i);
    stb_i = 1'b1; cyc_i = 1'b1; we_i = 1'b0; adr_i = A_LO; sel_i = 4'hF;
    @(posedge clk_i);
    #1;
    check("pre_rst_ack", ack_o, 1'b1);
    #2;
    rst_i = 1'b1;
    #1;
    check("arst_ack", ack_o, 1'b0);
    check("arst_int", interrupt, 1'b0);
    check("arst_irqvec", irq_vec, 4'b0);
    stb_i = 1'b0; cyc_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    rd(A_LO, rv, c2);
    check("post_rst_lo", rv, 32'h0);
    rd(A_HI, rv, c2);
    check("post_rst_hi", rv, 32'h0);
    rd(A_CTRL, rv, c2);
    check("post_rst_ctrl", rv, 32'h0);
    rd(A_IEN, rv, c2);
    check("post_rst_ien", rv, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
